// File: rtl/md_hilo_unit.sv
// rtl/md_hilo_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Optional MD_EARLY_OUT_EN: divides with b==0 or |a|<|b| complete one cycle after acceptance.
module md_hilo_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mul_or_div,
  input  logic              is_sign,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              reg_to_hi,
  input  logic              reg_to_lo,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_a, r_b, r_q, r_d, r_rem, r_hi, r_lo;
  logic              r_sign, r_busy, r_done;

  logic [DATA_W-1:0]   w_a_mag, w_b_mag, w_div_lo, w_div_hi;
  logic [2*DATA_W-1:0] w_a_ext, w_b_ext, w_prod;
  logic [DATA_W:0]     w_rem_sh, w_diff;
  logic                w_q_neg, w_r_neg, w_early;

  assign w_a_mag = (is_sign && src_a[DATA_W-1]) ? -src_a : src_a;
  assign w_b_mag = (is_sign && src_b[DATA_W-1]) ? -src_b : src_b;

  // Sign/zero extension to full width makes one unsigned multiply serve both modes.
  assign w_a_ext = r_sign ? {{DATA_W{r_a[DATA_W-1]}}, r_a} : {{DATA_W{1'b0}}, r_a};
  assign w_b_ext = r_sign ? {{DATA_W{r_b[DATA_W-1]}}, r_b} : {{DATA_W{1'b0}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Restoring step: r_q shifts the dividend out at the top and collects quotient bits at the bottom.
  assign w_rem_sh = {r_rem, r_q[DATA_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_d};

  assign w_q_neg  = r_sign && (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
  assign w_r_neg  = r_sign && r_a[DATA_W-1];
  assign w_div_lo = (r_b == '0) ? '1  : (w_q_neg ? -r_q : r_q);
  assign w_div_hi = (r_b == '0) ? r_a : (w_r_neg ? -r_rem : r_rem);

`ifdef MD_EARLY_OUT_EN
  assign w_early = (src_b == '0) || (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sign  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_a    <= src_a;
            r_b    <= src_b;
            r_sign <= is_sign;
            r_d    <= w_b_mag;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (!mul_or_div) begin
              r_state <= MUL;
            end else if (w_early) begin
              // Quotient is zero and remainder is the dividend; FIX applies the signs.
              r_state <= FIX;
              r_q     <= '0;
              r_rem   <= w_a_mag;
            end else begin
              r_state <= DIV;
              r_q     <= w_a_mag;
              r_rem   <= '0;
            end
          end else if (!start) begin
            if (reg_to_hi) r_hi <= src_a;
            if (reg_to_lo) r_lo <= src_a;
          end
        end
        MUL: begin
          if (flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_W'(MUL_LAT - 1)) begin
            r_hi    <= w_prod[2*DATA_W-1:DATA_W];
            r_lo    <= w_prod[DATA_W-1:0];
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DIV: begin
          if (flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_q   <= {r_q[DATA_W-2:0], ~w_diff[DATA_W]};
            r_rem <= w_diff[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
            if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= FIX;
            else r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!flush) begin
            r_hi   <= w_div_hi;
            r_lo   <= w_div_lo;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;
endmodule

// File: tb/tb_md_hilo_unit.sv
// tb/tb_md_hilo_unit.sv - scoreboard bench for md_hilo_unit (DATA_W=32, MUL_LAT=2)
module tb_md_hilo_unit;
  localparam int LMUL = 2;
  localparam int LDIV = 33;
`ifdef MD_EARLY_OUT_EN
  localparam int LEARLY = 1;
`else
  localparam int LEARLY = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, mul_or_div = 1'b0, is_sign = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        reg_to_hi = 1'b0, reg_to_lo = 1'b0, flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  md_hilo_unit #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mul_or_div(mul_or_div), .is_sign(is_sign),
    .src_a(src_a), .src_b(src_b), .reg_to_hi(reg_to_hi), .reg_to_lo(reg_to_lo),
    .flush(flush), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("hi_result", hi_out, mon_e.hi);
        chk("lo_result", lo_out, mon_e.lo);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic do_op(input logic md, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                       input logic mt_with_start, input logic mt_busy);
    exp_t e;
    start = 1'b1; mul_or_div = md; is_sign = sg; src_a = a; src_b = b;
    reg_to_lo = mt_with_start;
    @(posedge clk); #1;
    e.hi = ehi; e.lo = elo; e.cyc = cyc + lat;
    q.push_back(e);
    start = 1'b0; reg_to_lo = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("hi_hold_at_accept", hi_out, m_hi);
    chk("lo_hold_at_accept", lo_out, m_lo);
    if (mt_busy) begin
      reg_to_hi = 1'b1; src_a = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      reg_to_hi = 1'b0;
    end
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("busy_released", busy, 0);
    @(negedge clk); #1;
    chk("done_seen", 64'(q.size()), 0);
    m_hi = ehi; m_lo = elo;
  endtask

  task automatic mt(input logic to_hi, input logic [31:0] d);
    reg_to_hi = to_hi; reg_to_lo = !to_hi; src_a = d;
    @(posedge clk); #1;
    reg_to_hi = 1'b0; reg_to_lo = 1'b0;
    if (to_hi) m_hi = d; else m_lo = d;
    chk("mt_hi", hi_out, m_hi);
    chk("mt_lo", lo_out, m_lo);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi_out, 0);
    chk("reset_lo", lo_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LMUL, 0, 0);
    do_op(0, 0, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, LMUL, 0, 0);
    do_op(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, LMUL, 0, 0);
    do_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LMUL, 0, 0);
    do_op(1, 0, 32'd100, 32'd7, 32'd2, 32'd14, LDIV, 0, 1);
    do_op(1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LDIV, 0, 0);
    do_op(1, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, LDIV, 0, 0);
    do_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, LDIV, 0, 0);
    do_op(1, 0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, LDIV, 0, 0);
    do_op(1, 0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, LEARLY, 0, 0);
    do_op(1, 1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, LEARLY, 0, 0);
    do_op(1, 1, 32'd3, 32'd100, 32'd3, 32'd0, LEARLY, 0, 0);

    mt(1, 32'hA);
    mt(0, 32'hB);
    start = 1'b1; mul_or_div = 1'b1; is_sign = 1'b0; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("flush_busy_before", busy, 1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", busy, 0);
    chk("flush_hi_kept", hi_out, 32'hA);
    chk("flush_lo_kept", lo_out, 32'hB);
    do_op(0, 0, 32'd3, 32'd5, 32'd0, 32'd15, LMUL, 0, 0);

    mt(1, 32'h1234);
    do_op(0, 0, 32'd6, 32'd7, 32'd0, 32'd42, LMUL, 1, 0);

    start = 1'b1; mul_or_div = 1'b0; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_commit_busy", busy, 0);
    chk("flush_commit_hi", hi_out, m_hi);
    chk("flush_commit_lo", lo_out, m_lo);

    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_ignored", busy, 0);
    repeat (3) @(posedge clk);
    #1;

    mt(0, 32'h5555);
    start = 1'b1; mul_or_div = 1'b1; is_sign = 0; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_hi", hi_out, 0);
    chk("async_rst_lo", lo_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    do_op(0, 0, 32'd3, 32'd5, 32'd0, 32'd15, LMUL, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
